spi_tx_drain: RTL and testbench
===============================

// Module: spi_tx_drain
// PURPOSE
//   SPI master (mode 0, CPOL=0/CPHA=0) shift engine draining the TX data_buffer.
//   Pops words from the buffer head, serialises them MSB-first on mosi with a generated sclk and cs_n.
//   Captures miso into rx_data in parallel.
//   Consecutive available words are sent as one burst without releasing cs_n.
// PARAMETERS
//   WORD_SIZE  8  bits per SPI word; must match the buffer WORD_SIZE
//   CLK_DIV    4  clk cycles per sclk half-period; >=1
// PORTS
//   clk         in   1          system clock
//   rstn        in   1          asynchronous, active-low reset
//   enable      in   1          1 = start/continue transfers while buffer non-empty
//   buf_data    in   WORD_SIZE  buffer head word, valid while buf_empty=0
//   buf_empty   in   1          TX buffer empty
//   buf_read    out  1          1-cycle pop strobe to buffer
//   sclk        out  1          SPI clock, idle low
//   cs_n        out  1          chip select, active low
//   mosi        out  1          serial data out
//   miso        in   1          serial data in, sampled on sclk rising edge
//   rx_data     out  WORD_SIZE  last received word
//   rx_valid    out  1          1-cycle pulse when rx_data updates
//   busy        out  1          1 whenever state != IDLE
// BEHAVIOUR
//   Reset (async): cs_n=1, sclk=0, mosi=0, buf_read=0, rx_valid=0, busy=0, rx_data=0, state=IDLE.
//   All outputs registered. div_cnt clears on every state entry; a "tick" occurs when div_cnt==CLK_DIV-1.
//   IDLE:
//     - enable && !buf_empty -> latch buf_data into tx shreg; pulse buf_read; cs_n<=0;
//       mosi<=buf_data[MSB]; bit_cnt<=0; go SETUP.
//   SETUP: on tick: sclk<=1; shift miso into rx shreg; go SHIFT_HI.
//   SHIFT_HI: on tick: sclk<=0 (falling edge).
//     - bit_cnt!=WORD_SIZE-1 -> mosi<=next bit; bit_cnt++; go SHIFT_LO.
//     - bit_cnt==WORD_SIZE-1 -> rx_data<=rx shreg; pulse rx_valid. Then:
//       - enable && !buf_empty -> reload as in IDLE (buf_read pulse, new MSB on mosi, bit_cnt<=0); go SHIFT_LO.
//       - otherwise -> go HOLD.
//   SHIFT_LO: on tick: sclk<=1; sample miso; go SHIFT_HI.
//   HOLD: cs_n stays low; on tick: cs_n<=1; mosi<=0; go GAP.
//   GAP: cs_n high; on tick: go IDLE. Guarantees cs_n high >= CLK_DIV cycles between bursts.
//   Timing: if cs_n falls at cycle N, rising edge k (k=0..W-1) is at N+CLK_DIV*(2k+1).
//     Last falling edge is at N+2*CLK_DIV*W. cs_n rises CLK_DIV cycles later.
//   Burst: sclk period is unbroken across word boundaries; the next MSB appears on mosi at the last falling edge.
//   buf_read never asserts while buf_empty=1. At most one pop per word, issued in the cycle buf_data is latched.
//   enable is only checked in IDLE and at word boundaries. Deasserting it mid-word completes the current word.
//   Reset mid-word: immediate return to reset values; the partial word is discarded and no rx_valid is issued.
//     The popped word is not re-fetched.
//   Widths: bit_cnt $clog2(WORD_SIZE) bits; div_cnt $clog2(CLK_DIV+1) bits. Counters never wrap past their terminal values.
// TESTING  (WORD_SIZE=8, CLK_DIV=2)
//   Reset: hold rstn=0 with toggling inputs -> cs_n=1, sclk=0, mosi=0, buf_read=0, rx_valid=0, busy=0, rx_data=0x00.
//   Single word: buffer holds 0xA5, miso tied to mosi, enable=1 ->
//     - one buf_read;
//     - 8 sclk pulses, 4-clk period;
//     - mosi at rising edges = 1,0,1,0,0,1,0,1;
//     - cs_n low for 34 cycles;
//     - rx_valid once with rx_data=0xA5.
//   Burst: buffer holds 0x3C,0xC3 ->
//     - cs_n low continuously;
//     - 16 uninterrupted sclk pulses;
//     - 2 buf_read pulses, 32 cycles apart;
//     - rx_valid twice (0x3C then 0xC3 in loopback).
//   Empty: enable=1, buf_empty=1 for 100 cycles -> no buf_read, cs_n=1, sclk=0, busy=0.
//   Enable drop: enable->0 after the 3rd rising edge of 0x5A with 0xFF still queued ->
//     - 0x5A completes;
//     - cs_n rises 2 cycles after the last falling edge;
//     - no second buf_read.
//   Reset mid-word: rstn=0 after the 4th rising edge ->
//     - outputs return to reset values immediately; no rx_valid.
//     After release with a new word 0x81: a clean full transfer with rx_data=0x81.

Source files
------------

// File: rtl/spi_tx_drain_if.sv
// spi_tx_drain_if: TX buffer pop port plus SPI pins for the drain engine
interface spi_tx_drain_if #(
  parameter int WORD_SIZE = 8
);
  logic [WORD_SIZE-1:0] buf_data;
  logic                 buf_empty;
  logic                 buf_read;
  logic                 sclk;
  logic                 cs_n;
  logic                 mosi;
  logic                 miso;
  modport master (
    input  buf_data, buf_empty, miso,
    output buf_read, sclk, cs_n, mosi
  );
  modport slave (
    output buf_data, buf_empty, miso,
    input  buf_read, sclk, cs_n, mosi
  );
endinterface

// File: rtl/spi_tx_drain.sv
// spi_tx_drain: SPI mode-0 master popping TX buffer words and sending them MSB-first,
// keeping cs_n low across consecutive words and capturing miso in parallel
module spi_tx_drain #(
  parameter int WORD_SIZE = 8,
  parameter int CLK_DIV   = 4
) (
  input  logic                 clk,
  input  logic                 rstn,
  input  logic                 enable,
  spi_tx_drain_if.master       bus,
  output logic [WORD_SIZE-1:0] rx_data,
  output logic                 rx_valid,
  output logic                 busy
);
  localparam int BW = $clog2(WORD_SIZE);
  localparam int DW = $clog2(CLK_DIV + 1);
  localparam logic [BW-1:0] BIT_LAST = BW'(WORD_SIZE - 1);
  localparam logic [DW-1:0] DIV_LAST = DW'(CLK_DIV - 1);
  typedef enum logic [2:0] {IDLE, SETUP, SHIFT_HI, SHIFT_LO, HOLD, GAP} state_t;
  state_t               state_q, state_d;
  logic [BW-1:0]        bit_cnt_q, bit_cnt_d;
  logic [DW-1:0]        div_cnt_q, div_cnt_d;
  logic [WORD_SIZE-1:0] tx_q, tx_d, rx_sh_q, rx_sh_d, rx_data_q, rx_data_d;
  logic                 sclk_q, sclk_d, cs_n_q, cs_n_d, mosi_q, mosi_d;
  logic                 buf_read_q, buf_read_d, rx_valid_q, rx_valid_d, busy_q, busy_d;
  logic                 tick, load;
  assign tick = div_cnt_q == DIV_LAST;
  assign load = enable && !bus.buf_empty;
  always_comb begin
    state_d    = state_q;
    bit_cnt_d  = bit_cnt_q;
    tx_d       = tx_q;
    rx_sh_d    = rx_sh_q;
    rx_data_d  = rx_data_q;
    sclk_d     = sclk_q;
    cs_n_d     = cs_n_q;
    mosi_d     = mosi_q;
    buf_read_d = 1'b0;
    rx_valid_d = 1'b0;
    case (state_q)
      IDLE: if (load) begin
        tx_d       = bus.buf_data;
        buf_read_d = 1'b1;
        cs_n_d     = 1'b0;
        mosi_d     = bus.buf_data[WORD_SIZE-1];
        bit_cnt_d  = '0;
        state_d    = SETUP;
      end
      SETUP, SHIFT_LO: if (tick) begin
        sclk_d  = 1'b1;
        rx_sh_d = {rx_sh_q[WORD_SIZE-2:0], bus.miso};
        state_d = SHIFT_HI;
      end
      SHIFT_HI: if (tick) begin
        sclk_d = 1'b0;
        if (bit_cnt_q != BIT_LAST) begin
          mosi_d    = tx_q[WORD_SIZE-2];
          tx_d      = tx_q << 1;
          bit_cnt_d = bit_cnt_q + 1'b1;
          state_d   = SHIFT_LO;
        end else begin
          rx_data_d  = rx_sh_q;
          rx_valid_d = 1'b1;
          state_d    = load ? SHIFT_LO : HOLD;
          // Back-to-back word: reload on this falling edge so sclk never pauses
          if (load) begin
            tx_d       = bus.buf_data;
            buf_read_d = 1'b1;
            mosi_d     = bus.buf_data[WORD_SIZE-1];
            bit_cnt_d  = '0;
          end
        end
      end
      HOLD: if (tick) begin
        cs_n_d  = 1'b1;
        mosi_d  = 1'b0;
        state_d = GAP;
      end
      GAP: if (tick) state_d = IDLE;
      default: state_d = IDLE;
    endcase
    div_cnt_d = (state_q == IDLE || tick) ? '0 : div_cnt_q + 1'b1;
    busy_d    = state_d != IDLE;
  end
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state_q    <= IDLE;
      bit_cnt_q  <= '0;
      div_cnt_q  <= '0;
      tx_q       <= '0;
      rx_sh_q    <= '0;
      rx_data_q  <= '0;
      sclk_q     <= 1'b0;
      cs_n_q     <= 1'b1;
      mosi_q     <= 1'b0;
      buf_read_q <= 1'b0;
      rx_valid_q <= 1'b0;
      busy_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      bit_cnt_q  <= bit_cnt_d;
      div_cnt_q  <= div_cnt_d;
      tx_q       <= tx_d;
      rx_sh_q    <= rx_sh_d;
      rx_data_q  <= rx_data_d;
      sclk_q     <= sclk_d;
      cs_n_q     <= cs_n_d;
      mosi_q     <= mosi_d;
      buf_read_q <= buf_read_d;
      rx_valid_q <= rx_valid_d;
      busy_q     <= busy_d;
    end
  end
  assign bus.buf_read = buf_read_q;
  assign bus.sclk     = sclk_q;
  assign bus.cs_n     = cs_n_q;
  assign bus.mosi     = mosi_q;
  assign rx_data      = rx_data_q;
  assign rx_valid     = rx_valid_q;
  assign busy         = busy_q;
endmodule

// File: tb/tb_spi_tx_drain.sv
// tb_spi_tx_drain: directed checks of the SPI drain engine with a queue-backed buffer and miso looped to mosi
module tb_spi_tx_drain;
  logic       clk = 0;
  logic       rstn = 0;
  logic       enable = 0;
  logic [7:0] rx_data;
  logic       rx_valid, busy;
  spi_tx_drain_if #(.WORD_SIZE(8)) bus ();
  spi_tx_drain #(.WORD_SIZE(8), .CLK_DIV(2)) dut (
    .clk(clk), .rstn(rstn), .enable(enable), .bus(bus),
    .rx_data(rx_data), .rx_valid(rx_valid), .busy(busy)
  );
  assign bus.miso = bus.mosi;
  always #5 clk = ~clk;
  logic [7:0]  q[$];
  int          n_chk = 0, n_fail = 0;
  int          cyc = 0, n_rd = 0, last_rd = 0, prev_rd = 0, rd_bad = 0;
  int          n_rise = 0, last_rise = 0, last_fall = 0, run_rises = 0, gap_bad = 0;
  int          cs_run = 0, last_run = 0, n_runs = 0, cs_rise = 0, n_rxv = 0, act = 0;
  logic        sclk_p = 0;
  logic [31:0] mosi_bits = 0;
  logic [15:0] rx_hist = 0;
  int          rd0, rise0, rxv0, runs0, gap0, act0;
  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask
  task automatic drive_buf();
    bus.buf_empty = q.size() == 0;
    bus.buf_data  = q.size() != 0 ? q[0] : 8'h00;
  endtask
  task automatic step();
    @(negedge clk);
    cyc++;
    if (bus.buf_read) begin
      if (q.size() == 0) rd_bad++;
      else void'(q.pop_front());
      n_rd++;
      prev_rd = last_rd;
      last_rd = cyc;
    end
    if (bus.sclk && !sclk_p) begin
      n_rise++;
      mosi_bits = {mosi_bits[30:0], bus.mosi};
      if (run_rises > 0 && cyc - last_rise != 4) gap_bad++;
      last_rise = cyc;
      run_rises++;
    end
    if (!bus.sclk && sclk_p) last_fall = cyc;
    if (!bus.cs_n) cs_run++;
    else begin
      if (cs_run != 0) begin
        last_run = cs_run;
        n_runs++;
        cs_rise = cyc;
      end
      cs_run = 0;
      run_rises = 0;
    end
    if (rx_valid) begin
      n_rxv++;
      rx_hist = {rx_hist[7:0], rx_data};
    end
    if (!bus.cs_n || bus.sclk || busy) act++;
    sclk_p = bus.sclk;
    drive_buf();
  endtask
  task automatic snap();
    rd0 = n_rd; rise0 = n_rise; rxv0 = n_rxv; runs0 = n_runs; gap0 = gap_bad; act0 = act;
  endtask
  task automatic run_until_idle(input string tag);
    for (int i = 0; i < 20 && !busy; i++) step();
    for (int i = 0; i < 400 && busy; i++) step();
    check(tag, busy, 0);
  endtask
  task automatic wait_rises(input string tag, input int k);
    for (int i = 0; i < 200 && n_rise - rise0 < k; i++) step();
    check(tag, n_rise - rise0, k);
  endtask
  task automatic check_reset_outs(input string tag);
    check({tag, "_cs_n"}, bus.cs_n, 1);
    check({tag, "_sclk"}, bus.sclk, 0);
    check({tag, "_mosi"}, bus.mosi, 0);
    check({tag, "_buf_read"}, bus.buf_read, 0);
    check({tag, "_rx_valid"}, rx_valid, 0);
    check({tag, "_busy"}, busy, 0);
    check({tag, "_rx_data"}, rx_data, 0);
  endtask
  initial begin
    q = {8'h11, 8'h22};
    drive_buf();
    for (int i = 0; i < 10; i++) begin
      enable = i[0];
      step();
    end
    check_reset_outs("rst");
    check("rst_no_pop", n_rd, 0);
    q.delete();
    enable = 0;
    step();
    rstn = 1;
    step();
    // single word 0xA5
    snap();
    q = {8'hA5};
    drive_buf();
    enable = 1;
    run_until_idle("single_done");
    check("single_rd", n_rd - rd0, 1);
    check("single_rises", n_rise - rise0, 8);
    check("single_mosi", mosi_bits[7:0], 8'hA5);
    check("single_cs_low", last_run, 34);
    check("single_rxv", n_rxv - rxv0, 1);
    check("single_rx", rx_hist[7:0], 8'hA5);
    check("single_period", gap_bad - gap0, 0);
    // burst 0x3C, 0xC3
    snap();
    q = {8'h3C, 8'hC3};
    drive_buf();
    run_until_idle("burst_done");
    check("burst_runs", n_runs - runs0, 1);
    check("burst_cs_low", last_run, 66);
    check("burst_rises", n_rise - rise0, 16);
    check("burst_period", gap_bad - gap0, 0);
    check("burst_mosi", mosi_bits[15:0], 16'h3CC3);
    check("burst_rd", n_rd - rd0, 2);
    check("burst_rd_gap", last_rd - prev_rd, 32);
    check("burst_rxv", n_rxv - rxv0, 2);
    check("burst_rx", rx_hist, 16'h3CC3);
    // empty buffer with enable high
    snap();
    for (int i = 0; i < 100; i++) step();
    check("empty_rd", n_rd - rd0, 0);
    check("empty_activity", act - act0, 0);
    check("empty_busy", busy, 0);
    // enable dropped mid-word with another word still queued
    snap();
    q = {8'h5A, 8'hFF};
    drive_buf();
    wait_rises("drop_reach", 3);
    enable = 0;
    run_until_idle("drop_done");
    check("drop_rd", n_rd - rd0, 1);
    check("drop_rises", n_rise - rise0, 8);
    check("drop_rxv", n_rxv - rxv0, 1);
    check("drop_rx", rx_hist[7:0], 8'h5A);
    check("drop_cs_rise", cs_rise - last_fall, 2);
    check("drop_left", q.size(), 1);
    q.delete();
    drive_buf();
    for (int i = 0; i < 5; i++) step();
    // reset in the middle of a word
    snap();
    enable = 1;
    q = {8'h66};
    drive_buf();
    wait_rises("mid_reach", 4);
    rstn = 0;
    #1;
    check_reset_outs("mid");
    for (int i = 0; i < 4; i++) step();
    check("mid_no_rxv", n_rxv - rxv0, 0);
    check("mid_rd", n_rd - rd0, 1);
    rstn = 1;
    step();
    snap();
    q = {8'h81};
    drive_buf();
    run_until_idle("after_done");
    check("after_rd", n_rd - rd0, 1);
    check("after_rises", n_rise - rise0, 8);
    check("after_cs_low", last_run, 34);
    check("after_rxv", n_rxv - rxv0, 1);
    check("after_rx", rx_data, 8'h81);
    check("pop_when_empty", rd_bad, 0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
